bloom_filter_ctrl: RTL and testbench

// Control/sequencing block for the Bloom filter: hosts the Avalon-MM CSR slave and gates search_en for the ast_shift/hash datapath.

---
 rtl/bloom_filter_pkg.sv | 28 ++
 rtl/bloom_filter_ctrl_if.sv | 30 +++
 rtl/bloom_filter_lut_clear.sv | 86 ++++++++
 rtl/bloom_filter_ctrl.sv | 124 ++++++++++++
 tb/tb_bloom_filter_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bloom_filter_pkg.sv
// Shared CSR map, bit positions, version constant and controller state type
// for the Bloom filter control block.
package bloom_filter_pkg;

  localparam int unsigned BF_CSR_CTRL      = 0;
  localparam int unsigned BF_CSR_STATUS    = 1;
  localparam int unsigned BF_CSR_VERSION   = 2;
  localparam int unsigned BF_CSR_PKT_CNT   = 3;
  localparam int unsigned BF_CSR_MATCH_CNT = 4;

  localparam int unsigned BF_CTRL_SEARCH_EN   = 0;
  localparam int unsigned BF_CTRL_CLEAR_START = 1;
  localparam int unsigned BF_CTRL_CNT_RST     = 2;

  localparam int unsigned BF_STAT_CLEAR_BUSY     = 0;
  localparam int unsigned BF_STAT_SEARCH_EN      = 1;
  localparam int unsigned BF_STAT_LUT_WR_DROPPED = 2;
  localparam int unsigned BF_STAT_CLEAR_DONE     = 3;

  localparam logic [31:0] BF_CTRL_VERSION = 32'h0001_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/bloom_filter_ctrl_if.sv
// Avalon-MM host bus of the control block: CSR slave plus host LUT write port.
interface bloom_filter_ctrl_if #(
  parameter int unsigned AMM_CSR_ADDR_W = 4,
  parameter int unsigned AMM_CSR_DATA_W = 32,
  parameter int unsigned AMM_LUT_ADDR_W = 10,
  parameter int unsigned AMM_LUT_DATA_W = 32
);
  logic [AMM_CSR_ADDR_W-1:0] amm_slave_csr_address_i;
  logic                      amm_slave_csr_read_i;
  logic [AMM_CSR_DATA_W-1:0] amm_slave_csr_readdata_o;
  logic                      amm_slave_csr_write_i;
  logic [AMM_CSR_DATA_W-1:0] amm_slave_csr_writedata_i;
  logic [AMM_LUT_ADDR_W-1:0] amm_slave_lut_address_i;
  logic                      amm_slave_lut_write_i;
  logic [AMM_LUT_DATA_W-1:0] amm_slave_lut_writedata_i;

  modport slave (
    input  amm_slave_csr_address_i, amm_slave_csr_read_i, amm_slave_csr_write_i,
    input  amm_slave_csr_writedata_i,
    input  amm_slave_lut_address_i, amm_slave_lut_write_i, amm_slave_lut_writedata_i,
    output amm_slave_csr_readdata_o
  );

  modport master (
    output amm_slave_csr_address_i, amm_slave_csr_read_i, amm_slave_csr_write_i,
    output amm_slave_csr_writedata_i,
    output amm_slave_lut_address_i, amm_slave_lut_write_i, amm_slave_lut_writedata_i,
    input  amm_slave_csr_readdata_o
  );
endinterface

// File: rtl/bloom_filter_lut_clear.sv
// LUT write-port owner: registered host write forwarding in IDLE, or a
// drain-then-zero sweep over the whole table.
module bloom_filter_lut_clear
  import bloom_filter_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              busy_i,
  input  logic [ADDR_W-1:0] host_address_i,
  input  logic              host_write_i,
  input  logic [DATA_W-1:0] host_writedata_i,
  output logic [ADDR_W-1:0] lut_address_o,
  output logic              lut_write_o,
  output logic [DATA_W-1:0] lut_writedata_o,
  output logic              clear_busy_o,
  output logic              idle_next_o,
  output logic              done_o,
  output logic              host_drop_o
);

  ctrl_state_t       state, state_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic              host_wr_q;
  logic [ADDR_W-1:0] host_addr_q;
  logic [DATA_W-1:0] host_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state  <= state_next;
      addr_q <= addr_next;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = addr_q;
    done_o     = 1'b0;
    case (state)
      IDLE:  if (start_i) state_next = DRAIN;
      DRAIN: if (!busy_i) begin
        state_next = CLEAR;
        addr_next  = '0;
      end
      CLEAR: begin
        addr_next = addr_q + ADDR_W'(1);
        if (addr_q == '1) begin
          done_o     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_wr_q   <= 1'b0;
      host_addr_q <= '0;
      host_data_q <= '0;
    end else begin
      host_wr_q <= host_write_i && (state == IDLE);
      if (host_write_i && (state == IDLE)) begin
        host_addr_q <= host_address_i;
        host_data_q <= host_writedata_i;
      end
    end
  end

  // Sweep writes come straight from the state register so an async reset
  // removes them in the same cycle.
  assign lut_write_o     = (state == CLEAR) || host_wr_q;
  assign lut_address_o   = (state == CLEAR) ? addr_q : host_addr_q;
  assign lut_writedata_o = (state == CLEAR) ? '0 : host_data_q;

  assign clear_busy_o = (state != IDLE);
  assign idle_next_o  = (state_next == IDLE);
  assign host_drop_o  = host_write_i && (state != IDLE);

endmodule

// File: rtl/bloom_filter_ctrl.sv
// Bloom filter control: CSR slave, search enable gating, LUT clear sequencing
// and packet/match statistics.
module bloom_filter_ctrl
  import bloom_filter_pkg::*;
#(
  parameter int unsigned AMM_CSR_ADDR_W = 4,
  parameter int unsigned AMM_CSR_DATA_W = 32,
  parameter int unsigned AMM_LUT_ADDR_W = 10,
  parameter int unsigned AMM_LUT_DATA_W = 32
) (
  input  logic                      main_clk_i,
  input  logic                      main_arst_i,
  bloom_filter_ctrl_if.slave        amm,
  output logic [AMM_LUT_ADDR_W-1:0] lut_address_o,
  output logic                      lut_write_o,
  output logic [AMM_LUT_DATA_W-1:0] lut_writedata_o,
  output logic                      search_en_o,
  input  logic                      datapath_busy_i,
  input  logic                      pkt_done_i,
  input  logic                      match_i
);

  logic                      wr_ctrl, wr_status;
  logic                      clear_start, cnt_rst;
  logic                      search_en_q, search_en_next;
  logic                      clear_busy, idle_next, clear_done_pulse, host_drop;
  logic                      lut_wr_dropped, clear_done;
  logic [AMM_CSR_DATA_W-1:0] pkt_cnt, match_cnt;
  logic [AMM_CSR_DATA_W-1:0] rd_mux;
  logic                      unused_wdata;

  assign wr_ctrl   = amm.amm_slave_csr_write_i &&
                     (amm.amm_slave_csr_address_i == AMM_CSR_ADDR_W'(BF_CSR_CTRL));
  assign wr_status = amm.amm_slave_csr_write_i &&
                     (amm.amm_slave_csr_address_i == AMM_CSR_ADDR_W'(BF_CSR_STATUS));

  assign clear_start    = wr_ctrl && amm.amm_slave_csr_writedata_i[BF_CTRL_CLEAR_START];
  assign cnt_rst        = wr_ctrl && amm.amm_slave_csr_writedata_i[BF_CTRL_CNT_RST];
  assign search_en_next = wr_ctrl ? amm.amm_slave_csr_writedata_i[BF_CTRL_SEARCH_EN]
                                  : search_en_q;
  assign unused_wdata   = ^amm.amm_slave_csr_writedata_i[AMM_CSR_DATA_W-1:3];

  bloom_filter_lut_clear #(
    .ADDR_W (AMM_LUT_ADDR_W),
    .DATA_W (AMM_LUT_DATA_W)
  ) u_lut_clear (
    .clk              (main_clk_i),
    .rst              (main_arst_i),
    .start_i          (clear_start),
    .busy_i           (datapath_busy_i),
    .host_address_i   (amm.amm_slave_lut_address_i),
    .host_write_i     (amm.amm_slave_lut_write_i),
    .host_writedata_i (amm.amm_slave_lut_writedata_i),
    .lut_address_o    (lut_address_o),
    .lut_write_o      (lut_write_o),
    .lut_writedata_o  (lut_writedata_o),
    .clear_busy_o     (clear_busy),
    .idle_next_o      (idle_next),
    .done_o           (clear_done_pulse),
    .host_drop_o      (host_drop)
  );

  // Gating uses next-cycle values so search_en_o follows a CTRL write by one cycle.
  always_ff @(posedge main_clk_i or posedge main_arst_i) begin
    if (main_arst_i) begin
      search_en_q <= 1'b0;
      search_en_o <= 1'b0;
    end else begin
      search_en_q <= search_en_next;
      search_en_o <= search_en_next && idle_next;
    end
  end

  always_ff @(posedge main_clk_i or posedge main_arst_i) begin
    if (main_arst_i) begin
      lut_wr_dropped <= 1'b0;
      clear_done     <= 1'b0;
    end else begin
      if (wr_status) begin
        lut_wr_dropped <= 1'b0;
        clear_done     <= 1'b0;
      end
      if (host_drop)        lut_wr_dropped <= 1'b1;
      if (clear_done_pulse) clear_done     <= 1'b1;
    end
  end

  always_ff @(posedge main_clk_i or posedge main_arst_i) begin
    if (main_arst_i) begin
      pkt_cnt   <= '0;
      match_cnt <= '0;
    end else if (cnt_rst) begin
      pkt_cnt   <= '0;
      match_cnt <= '0;
    end else begin
      if (pkt_done_i) pkt_cnt   <= pkt_cnt + AMM_CSR_DATA_W'(1);
      if (match_i)    match_cnt <= match_cnt + AMM_CSR_DATA_W'(1);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (amm.amm_slave_csr_address_i)
      AMM_CSR_ADDR_W'(BF_CSR_CTRL):
        rd_mux[BF_CTRL_SEARCH_EN] = search_en_q;
      AMM_CSR_ADDR_W'(BF_CSR_STATUS): begin
        rd_mux[BF_STAT_CLEAR_BUSY]     = clear_busy;
        rd_mux[BF_STAT_SEARCH_EN]      = search_en_o;
        rd_mux[BF_STAT_LUT_WR_DROPPED] = lut_wr_dropped;
        rd_mux[BF_STAT_CLEAR_DONE]     = clear_done;
      end
      AMM_CSR_ADDR_W'(BF_CSR_VERSION):   rd_mux = AMM_CSR_DATA_W'(BF_CTRL_VERSION);
      AMM_CSR_ADDR_W'(BF_CSR_PKT_CNT):   rd_mux = pkt_cnt;
      AMM_CSR_ADDR_W'(BF_CSR_MATCH_CNT): rd_mux = match_cnt;
      default:                           rd_mux = '0;
    endcase
  end

  always_ff @(posedge main_clk_i or posedge main_arst_i) begin
    if (main_arst_i)                    amm.amm_slave_csr_readdata_o <= '0;
    else if (amm.amm_slave_csr_read_i)  amm.amm_slave_csr_readdata_o <= rd_mux;
  end

endmodule

// File: tb/tb_bloom_filter_ctrl.sv
// Directed-plus-random bench for bloom_filter_ctrl against a small behavioural model.
module tb_bloom_filter_ctrl;
  import bloom_filter_pkg::*;

  localparam int unsigned CA = 4, CD = 32, LA = 10, LD = 32;
  localparam int unsigned DEPTH = 1 << LA;

  logic          clk = 1'b0;
  logic          rst;
  logic [LA-1:0] lut_address;
  logic          lut_write;
  logic [LD-1:0] lut_writedata;
  logic          search_en, busy, pkt_done, match;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Behavioural model state
  bit          m_en, m_dropped, m_done;
  logic [31:0] m_pkt, m_match;

  bloom_filter_ctrl_if #(.AMM_CSR_ADDR_W(CA), .AMM_CSR_DATA_W(CD),
                         .AMM_LUT_ADDR_W(LA), .AMM_LUT_DATA_W(LD)) bus ();

  bloom_filter_ctrl #(.AMM_CSR_ADDR_W(CA), .AMM_CSR_DATA_W(CD),
                      .AMM_LUT_ADDR_W(LA), .AMM_LUT_DATA_W(LD)) dut (
    .main_clk_i      (clk),
    .main_arst_i     (rst),
    .amm             (bus.slave),
    .lut_address_o   (lut_address),
    .lut_write_o     (lut_write),
    .lut_writedata_o (lut_writedata),
    .search_en_o     (search_en),
    .datapath_busy_i (busy),
    .pkt_done_i      (pkt_done),
    .match_i         (match)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_exp(input bit sweeping);
    logic [31:0] s;
    s = '0;
    s[0] = sweeping;
    s[1] = m_en && !sweeping;
    s[2] = m_dropped;
    s[3] = m_done;
    return s;
  endfunction

  task automatic csr_write(input int unsigned addr, input logic [31:0] data);
    bus.amm_slave_csr_address_i   = CA'(addr);
    bus.amm_slave_csr_writedata_i = data;
    bus.amm_slave_csr_write_i     = 1'b1;
    tick();
    bus.amm_slave_csr_write_i     = 1'b0;
  endtask

  task automatic csr_read(input int unsigned addr, output logic [31:0] data);
    bus.amm_slave_csr_address_i = CA'(addr);
    bus.amm_slave_csr_read_i    = 1'b1;
    tick();
    bus.amm_slave_csr_read_i    = 1'b0;
    data = bus.amm_slave_csr_readdata_o;
  endtask

  task automatic host_lut_write(input logic [LA-1:0] a, input logic [LD-1:0] d);
    bus.amm_slave_lut_address_i   = a;
    bus.amm_slave_lut_writedata_i = d;
    bus.amm_slave_lut_write_i     = 1'b1;
    tick();
    bus.amm_slave_lut_write_i     = 1'b0;
  endtask

  // Follows a sweep from DRAIN to its end, checking every zero write in order.
  task automatic run_sweep(input bit inject);
    int unsigned n = 0;
    int unsigned guard = 0;
    bit started = 1'b0;
    while (guard < DEPTH + 50) begin
      if (lut_write) begin
        check("sweep_addr", 64'(lut_address), 64'(n));
        check("sweep_data", 64'(lut_writedata), 64'd0);
        n++;
        started = 1'b1;
      end else if (started) begin
        break;
      end
      if (inject && n == 300) begin
        bus.amm_slave_lut_address_i   = LA'(7);
        bus.amm_slave_lut_writedata_i = 32'hDEAD_BEEF;
        bus.amm_slave_lut_write_i     = 1'b1;
        m_dropped = 1'b1;
      end
      tick();
      bus.amm_slave_lut_write_i = 1'b0;
      guard++;
    end
    check("sweep_count", 64'(n), 64'(DEPTH));
    m_done = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [LA-1:0] ra;
    logic [LD-1:0] rdat;
    bit w;
    bit found;

    rst = 1'b1;
    busy = 1'b0; pkt_done = 1'b0; match = 1'b0;
    bus.amm_slave_csr_address_i = '0; bus.amm_slave_csr_read_i = 1'b0;
    bus.amm_slave_csr_write_i = 1'b0; bus.amm_slave_csr_writedata_i = '0;
    bus.amm_slave_lut_address_i = '0; bus.amm_slave_lut_write_i = 1'b0;
    bus.amm_slave_lut_writedata_i = '0;
    m_en = 0; m_dropped = 0; m_done = 0; m_pkt = '0; m_match = '0;

    // 1. reset state and CSR read-back
    #12;
    check("rst_search_en", 64'(search_en), 64'd0);
    check("rst_lut_write", 64'(lut_write), 64'd0);
    check("rst_lut_addr", 64'(lut_address), 64'd0);
    check("rst_lut_data", 64'(lut_writedata), 64'd0);
    check("rst_readdata", 64'(bus.amm_slave_csr_readdata_o), 64'd0);
    rst = 1'b0;
    tick();
    csr_read(BF_CSR_CTRL, rd);   check("rd_ctrl0", 64'(rd), 64'd0);
    csr_read(BF_CSR_STATUS, rd); check("rd_status0", 64'(rd), 64'd0);
    bus.amm_slave_csr_address_i = CA'(BF_CSR_VERSION);
    bus.amm_slave_csr_read_i    = 1'b1;
    check("rd_ver_before_edge", 64'(bus.amm_slave_csr_readdata_o), 64'd0);
    tick();
    bus.amm_slave_csr_read_i = 1'b0;
    check("rd_version", 64'(bus.amm_slave_csr_readdata_o), 64'(BF_CTRL_VERSION));
    bus.amm_slave_csr_address_i = CA'(BF_CSR_PKT_CNT);
    tick();
    check("rd_hold", 64'(bus.amm_slave_csr_readdata_o), 64'(BF_CTRL_VERSION));
    csr_read(BF_CSR_PKT_CNT, rd);   check("rd_pkt0", 64'(rd), 64'd0);
    csr_read(BF_CSR_MATCH_CNT, rd); check("rd_match0", 64'(rd), 64'd0);
    csr_read(9, rd);                check("rd_unmapped", 64'(rd), 64'd0);

    // 2. search enable and host LUT forwarding
    csr_write(BF_CSR_CTRL, 32'h1); m_en = 1'b1;
    check("search_en_on", 64'(search_en), 64'd1);
    host_lut_write(LA'(5), 32'hA5);
    check("host_wr", 64'(lut_write), 64'd1);
    check("host_addr", 64'(lut_address), 64'd5);
    check("host_data", 64'(lut_writedata), 64'hA5);
    tick();
    check("host_wr_single", 64'(lut_write), 64'd0);
    for (int i = 0; i < 30; i++) begin
      w    = 1'($urandom_range(0, 1));
      ra   = LA'($urandom);
      rdat = $urandom;
      bus.amm_slave_lut_address_i   = ra;
      bus.amm_slave_lut_writedata_i = rdat;
      bus.amm_slave_lut_write_i     = w;
      tick();
      check("rnd_host_wr", 64'(lut_write), 64'(w));
      if (w) begin
        check("rnd_host_addr", 64'(lut_address), 64'(ra));
        check("rnd_host_data", 64'(lut_writedata), 64'(rdat));
      end
    end
    bus.amm_slave_lut_write_i = 1'b0;
    tick();

    // Same-cycle read and write of CTRL returns the old value
    bus.amm_slave_csr_address_i   = CA'(BF_CSR_CTRL);
    bus.amm_slave_csr_writedata_i = 32'h0;
    bus.amm_slave_csr_read_i      = 1'b1;
    bus.amm_slave_csr_write_i     = 1'b1;
    tick();
    bus.amm_slave_csr_read_i  = 1'b0;
    bus.amm_slave_csr_write_i = 1'b0;
    m_en = 1'b0;
    check("rw_same_cycle", 64'(bus.amm_slave_csr_readdata_o), 64'd1);
    check("search_en_off", 64'(search_en), 64'd0);
    csr_write(BF_CSR_CTRL, 32'h1); m_en = 1'b1;
    check("search_en_back", 64'(search_en), 64'd1);

    // 3/4. drain with busy datapath, dropped writes, full sweep
    busy = 1'b1;
    repeat (10) tick();
    csr_write(BF_CSR_CTRL, 32'h3);
    check("drain_search_en", 64'(search_en), 64'd0);
    repeat (5) tick();
    check("drain_no_write", 64'(lut_write), 64'd0);
    host_lut_write(LA'(9), 32'h1234);
    m_dropped = 1'b1;
    check("drain_drop", 64'(lut_write), 64'd0);
    csr_write(BF_CSR_CTRL, 32'h3);
    csr_read(BF_CSR_STATUS, rd);
    check("drain_status", 64'(rd), 64'(status_exp(1'b1)));
    busy = 1'b0;
    run_sweep(1'b1);
    check("post_sweep_no_write", 64'(lut_write), 64'd0);
    check("post_sweep_search_en", 64'(search_en), 64'd1);
    csr_read(BF_CSR_STATUS, rd);
    check("status_after_sweep", 64'(rd), 64'(status_exp(1'b0)));
    csr_write(BF_CSR_STATUS, 32'h0); m_dropped = 1'b0; m_done = 1'b0;
    csr_read(BF_CSR_STATUS, rd);
    check("status_cleared", 64'(rd), 64'(status_exp(1'b0)));

    // 5. counters
    for (int i = 0; i < 200; i++) begin
      pkt_done = 1'($urandom_range(0, 1));
      match    = ($urandom_range(0, 3) == 0);
      tick();
      if (pkt_done) m_pkt++;
      if (match)    m_match++;
    end
    pkt_done = 1'b0; match = 1'b0;
    csr_read(BF_CSR_PKT_CNT, rd);   check("rnd_pkt_cnt", 64'(rd), 64'(m_pkt));
    csr_read(BF_CSR_MATCH_CNT, rd); check("rnd_match_cnt", 64'(rd), 64'(m_match));
    bus.amm_slave_csr_address_i   = CA'(BF_CSR_CTRL);
    bus.amm_slave_csr_writedata_i = 32'h5;
    bus.amm_slave_csr_write_i     = 1'b1;
    match = 1'b1; pkt_done = 1'b1;
    tick();
    bus.amm_slave_csr_write_i = 1'b0; match = 1'b0; pkt_done = 1'b0;
    m_pkt = '0; m_match = '0;
    csr_read(BF_CSR_PKT_CNT, rd);   check("cnt_rst_pkt", 64'(rd), 64'd0);
    csr_read(BF_CSR_MATCH_CNT, rd); check("cnt_rst_match", 64'(rd), 64'd0);
    csr_read(BF_CSR_CTRL, rd);      check("ctrl_w1_reads0", 64'(rd), 64'd1);
    for (int i = 0; i < 3; i++) begin
      pkt_done = 1'b1; tick(); pkt_done = 1'b0; tick(); m_pkt++;
    end
    for (int i = 0; i < 2; i++) begin
      match = 1'b1; tick(); match = 1'b0; tick(); m_match++;
    end
    csr_read(BF_CSR_PKT_CNT, rd);   check("pkt_cnt3", 64'(rd), 64'(m_pkt));
    csr_read(BF_CSR_MATCH_CNT, rd); check("match_cnt2", 64'(rd), 64'(m_match));

    // 6. async reset in mid-sweep, then a clean full sweep
    csr_write(BF_CSR_CTRL, 32'h3);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (lut_write && lut_address == LA'(100)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reach_addr100", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_lut_write", 64'(lut_write), 64'd0);
    check("arst_lut_addr", 64'(lut_address), 64'd0);
    check("arst_search_en", 64'(search_en), 64'd0);
    m_en = 0; m_dropped = 0; m_done = 0; m_pkt = '0; m_match = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("after_arst_write", 64'(lut_write), 64'd0);
    csr_read(BF_CSR_STATUS, rd);  check("arst_status", 64'(rd), 64'(status_exp(1'b0)));
    csr_read(BF_CSR_CTRL, rd);    check("arst_ctrl", 64'(rd), 64'd0);
    csr_read(BF_CSR_PKT_CNT, rd); check("arst_pkt", 64'(rd), 64'(m_pkt));
    csr_write(BF_CSR_CTRL, 32'h2);
    run_sweep(1'b0);
    check("sweep2_search_en", 64'(search_en), 64'd0);
    csr_read(BF_CSR_STATUS, rd);
    check("sweep2_status", 64'(rd), 64'(status_exp(1'b0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
